// File: rtl/pci_master.sv
// PCI initiator: single/burst read and write transactions on the shared AD/CBE bus.
// Define PCI_MASTER_ABORT_EN to enable the master-abort timer (no DEVSEL within 5 data cycles).
module pci_master (
  input  logic        CLK,
  input  logic        RST,
  inout  tri   [31:0] AD,
  output logic [3:0]  CBE,
  output logic        FRAME,
  output logic        IRDY,
  input  logic        TRDY,
  input  logic        DEVSEL,
  input  logic        req,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [3:0]  len,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        wdata_rd,
  output logic [31:0] rdata,
  output logic        rdata_vld,
  output logic        busy,
  output logic        done,
  output logic        abort
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  localparam logic [3:0] CMD_WRITE = 4'b0011;

  logic [1:0]  state;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        is_wr;
  logic [3:0]  be_q;
  logic [4:0]  rem;
  logic        xfer;
  logic        last;
  logic        abort_now;

  assign AD   = ad_oe ? ad_out : 'z;
  assign xfer = (state == S_DATA) && !IRDY && !TRDY;
  assign last = (rem == 5'd1);

  // Combinational pop strobe: the source advances on the same edge that loads wdata.
  assign wdata_rd = is_wr && !abort_now &&
                    ((state == S_ADDR) || (xfer && !last));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
      is_wr     <= 1'b0;
      be_q      <= '1;
      rem       <= '0;
      CBE       <= '1;
      FRAME     <= 1'b1;
      IRDY      <= 1'b1;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rdata_vld <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state  <= S_ADDR;
            FRAME  <= 1'b0;
            CBE    <= cmd;
            ad_out <= addr;
            ad_oe  <= 1'b1;
            is_wr  <= (cmd == CMD_WRITE);
            be_q   <= be;
            rem    <= (len == 4'd0) ? 5'd16 : {1'b0, len};
            busy   <= 1'b1;
          end
        end
        S_ADDR: begin
          state <= S_DATA;
          IRDY  <= 1'b0;
          CBE   <= be_q;
          FRAME <= last;
          if (is_wr) ad_out <= wdata;
          else       ad_oe  <= 1'b0;
        end
        S_DATA: begin
          if (abort_now || (xfer && last)) begin
            state <= S_TURN;
            FRAME <= 1'b1;
            IRDY  <= 1'b1;
            CBE   <= '1;
            ad_oe <= 1'b0;
            busy  <= 1'b0;
            done  <= !abort_now;
          end else if (xfer && rem == 5'd2) begin
            FRAME <= 1'b1;
          end
          if (xfer && !abort_now) begin
            rem <= rem - 5'd1;
            if (is_wr && !last) ad_out <= wdata;
            if (!is_wr) begin
              rdata     <= AD;
              rdata_vld <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PCI_MASTER_ABORT_EN
  logic [2:0] ab_cnt;
  logic       dev_seen;

  // Fires at the end of the fifth data cycle with no DEVSEL claim seen.
  assign abort_now = (state == S_DATA) && DEVSEL && !dev_seen && (ab_cnt == 3'd4);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ab_cnt   <= '0;
      dev_seen <= 1'b0;
      abort    <= 1'b0;
    end else begin
      abort <= abort_now;
      if (state == S_ADDR) begin
        ab_cnt   <= '0;
        dev_seen <= 1'b0;
      end else if (state == S_DATA) begin
        if (!DEVSEL)        dev_seen <= 1'b1;
        else if (!dev_seen) ab_cnt   <= ab_cnt + 3'd1;
      end
    end
  end
`else
  logic unused_devsel;
  assign unused_devsel = DEVSEL;
  assign abort_now     = 1'b0;
  assign abort         = 1'b0;
`endif

endmodule

// File: tb/tb_pci_master.sv
// Directed bench for pci_master: reset, single read, write burst, wait states, 16-word burst, abort/stall.
module tb_pci_master;

  logic        CLK = 1'b0;
  logic        RST;
  tri1  [31:0] AD;
  logic [3:0]  CBE;
  logic        FRAME, IRDY, TRDY, DEVSEL;
  logic        req;
  logic [3:0]  cmd, len, be;
  logic [31:0] addr, wdata, rdata;
  logic        wdata_rd, rdata_vld, busy, done, abort;

  logic [31:0] tgt_ad;
  logic        tgt_oe;
  logic [31:0] wq [16];
  logic [3:0]  widx;

  int total, bad, rd_cnt, vld_cnt, done_cnt;

  always #5 CLK = ~CLK;

  assign AD = tgt_oe ? tgt_ad : 'z;
  always_comb wdata = wq[widx];

  pci_master dut (
    .CLK(CLK), .RST(RST), .AD(AD), .CBE(CBE), .FRAME(FRAME), .IRDY(IRDY),
    .TRDY(TRDY), .DEVSEL(DEVSEL), .req(req), .cmd(cmd), .addr(addr),
    .len(len), .be(be), .wdata(wdata), .wdata_rd(wdata_rd), .rdata(rdata),
    .rdata_vld(rdata_vld), .busy(busy), .done(done), .abort(abort)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic tick;
    logic rd;
    #3 rd = wdata_rd;
    @(posedge CLK);
    #1;
    if (rd) begin
      widx++;
      rd_cnt++;
    end
    if (rdata_vld) vld_cnt++;
    if (done) done_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; rd_cnt = 0; vld_cnt = 0; done_cnt = 0;
    RST = 1'b0; req = 1'b0; cmd = '0; addr = '0; len = '0; be = 4'hF;
    TRDY = 1'b1; DEVSEL = 1'b1; tgt_oe = 1'b0; tgt_ad = '0; widx = '0;
    for (int i = 0; i < 16; i++) wq[i] = '0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_frame", FRAME, 1);
    check("rst_irdy", IRDY, 1);
    check("rst_cbe", CBE, 4'hF);
    check("rst_ad", AD, 32'hFFFF_FFFF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_vld", rdata_vld, 0);
    check("rst_wrd", wdata_rd, 0);
    check("rst_abort", abort, 0);
    RST = 1'b1;
    tick; tick;

    // single read
    req = 1'b1; cmd = 4'b0010; addr = 32'h0; len = 4'd1; be = 4'h0;
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick; req = 1'b0;
    check("sr_adr_frame", FRAME, 0);
    check("sr_adr_irdy", IRDY, 1);
    check("sr_adr_ad", AD, 32'h0);
    check("sr_adr_cbe", CBE, 4'b0010);
    check("sr_adr_busy", busy, 1);
    tick; tgt_oe = 1'b1; tgt_ad = 32'd51653;
    check("sr_dat_irdy", IRDY, 0);
    check("sr_dat_frame", FRAME, 1);
    check("sr_dat_cbe", CBE, 4'h0);
    tick;
    check("sr_rdata", rdata, 32'd51653);
    check("sr_vld", rdata_vld, 1);
    check("sr_done", done, 1);
    check("sr_busy", busy, 0);
    check("sr_turn_irdy", IRDY, 1);
    check("sr_turn_cbe", CBE, 4'hF);
    tgt_oe = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1;
    tick;
    check("sr_vld_clr", rdata_vld, 0);
    check("sr_done_clr", done, 0);
    check("sr_idle_ad", AD, 32'hFFFF_FFFF);

    // zero-wait write burst of 3
    wq[0] = 32'd1; wq[1] = 32'd2; wq[2] = 32'd3; widx = '0; rd_cnt = 0;
    req = 1'b1; cmd = 4'b0011; addr = 32'h100; len = 4'd3; be = 4'h5;
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick; req = 1'b0;
    check("wb_adr_ad", AD, 32'h100);
    check("wb_adr_cbe", CBE, 4'b0011);
    check("wb_adr_wrd", wdata_rd, 1);
    tick;
    check("wb_ad1", AD, 32'd1);
    check("wb_frame1", FRAME, 0);
    check("wb_cbe1", CBE, 4'h5);
    check("wb_irdy1", IRDY, 0);
    tick;
    check("wb_ad2", AD, 32'd2);
    check("wb_frame2", FRAME, 0);
    tick;
    check("wb_ad3", AD, 32'd3);
    check("wb_frame3", FRAME, 1);
    check("wb_wrd3", wdata_rd, 0);
    tick;
    check("wb_done", done, 1);
    check("wb_irdy", IRDY, 1);
    check("wb_ad_float", AD, 32'hFFFF_FFFF);
    check("wb_rd_cnt", rd_cnt, 3);
    TRDY = 1'b1; DEVSEL = 1'b1;
    tick;

    // read of 2 with two wait states before each transfer
    vld_cnt = 0;
    req = 1'b1; cmd = 4'b0010; addr = 32'h200; len = 4'd2; be = 4'h0;
    TRDY = 1'b1; DEVSEL = 1'b0;
    tick; req = 1'b0;
    tick; tgt_oe = 1'b1; tgt_ad = 32'hCAFE_0001;
    tick; tick;
    check("ws_irdy", IRDY, 0);
    check("ws_frame", FRAME, 0);
    check("ws_novld", vld_cnt, 0);
    TRDY = 1'b0;
    tick;
    check("ws_rdata1", rdata, 32'hCAFE_0001);
    check("ws_vld1", rdata_vld, 1);
    check("ws_frame_last", FRAME, 1);
    TRDY = 1'b1; tgt_ad = 32'hCAFE_0002;
    tick; tick;
    check("ws_hold_irdy", IRDY, 0);
    check("ws_hold_frame", FRAME, 1);
    check("ws_hold_vld", rdata_vld, 0);
    check("ws_hold_rdata", rdata, 32'hCAFE_0001);
    TRDY = 1'b0;
    tick;
    check("ws_rdata2", rdata, 32'hCAFE_0002);
    check("ws_done", done, 1);
    check("ws_vld_cnt", vld_cnt, 2);
    tgt_oe = 1'b0; TRDY = 1'b1; DEVSEL = 1'b1;
    tick;

    // len=0 means 16 words
    for (int i = 0; i < 16; i++) wq[i] = 32'h1000 + i;
    widx = '0; rd_cnt = 0; done_cnt = 0;
    req = 1'b1; cmd = 4'b0011; addr = 32'h300; len = 4'd0; be = 4'h0;
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick; req = 1'b0;
    tick;
    for (int k = 0; k < 16; k++) begin
      check("l16_ad", AD, 32'h1000 + k);
      if (k == 14) check("l16_frame_lo", FRAME, 0);
      if (k == 15) check("l16_frame_hi", FRAME, 1);
      tick;
    end
    check("l16_done", done, 1);
    check("l16_rd_cnt", rd_cnt, 16);
    check("l16_done_cnt", done_cnt, 1);
    TRDY = 1'b1; DEVSEL = 1'b1;
    tick;

    // no target claims the transaction
    done_cnt = 0;
    req = 1'b1; cmd = 4'b0010; addr = 32'h400; len = 4'd1; be = 4'h0;
    TRDY = 1'b1; DEVSEL = 1'b1;
    tick; req = 1'b0;
    tick;
`ifdef PCI_MASTER_ABORT_EN
    repeat (4) tick;
    check("ab_pre_irdy", IRDY, 0);
    check("ab_pre_abort", abort, 0);
    tick;
    check("ab_abort", abort, 1);
    check("ab_frame", FRAME, 1);
    check("ab_irdy", IRDY, 1);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    tick;
    check("ab_abort_clr", abort, 0);
    check("ab_done_cnt", done_cnt, 0);
`else
    repeat (20) tick;
    check("st_irdy", IRDY, 0);
    check("st_busy", busy, 1);
    check("st_abort", abort, 0);
    check("st_done_cnt", done_cnt, 0);
    RST = 1'b0;
    #2 RST = 1'b1;
    tick;
`endif

    // asynchronous reset in the middle of a write burst
    for (int i = 0; i < 4; i++) wq[i] = 32'h5000 + i;
    widx = '0;
    req = 1'b1; cmd = 4'b0011; addr = 32'h500; len = 4'd4; be = 4'h0;
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick; req = 1'b0;
    tick; tick;
    TRDY = 1'b1;
    check("mr_pre_ad", AD, 32'h5001);
    #2 RST = 1'b0;
    #1;
    check("mr_frame", FRAME, 1);
    check("mr_irdy", IRDY, 1);
    check("mr_cbe", CBE, 4'hF);
    check("mr_ad", AD, 32'hFFFF_FFFF);
    check("mr_busy", busy, 0);
    #1 RST = 1'b1;
    tick;
    check("mr_idle_frame", FRAME, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
